// File: rtl/encoder_pkg.sv
// Shared encodings for the encoder front end: direction modes, pulse codes and
// the line-trigger FSM states.
package encoder_pkg;

  localparam logic [1:0] DM_FWD  = 2'd0;
  localparam logic [1:0] DM_REV  = 2'd1;
  localparam logic [1:0] DM_BOTH = 2'd2;
  localparam logic [1:0] DM_NONE = 2'd3;

  localparam logic [1:0] PD_FWD = 2'b01;
  localparam logic [1:0] PD_REV = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRIG    = 2'd1,
    ST_HOLDOFF = 2'd2
  } trig_state_t;

  // A simultaneous fwd+rev strobe (2'b11) never qualifies in any mode.
  function automatic logic pulse_accepted(input logic [1:0] mode, input logic [1:0] pd);
    logic ok;
    case (mode)
      DM_FWD:  ok = (pd == PD_FWD);
      DM_REV:  ok = (pd == PD_REV);
      DM_BOTH: ok = (pd == PD_FWD) || (pd == PD_REV);
      DM_NONE: ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/enc_position_cnt.sv
// Signed up/down step counter tracking encoder position; clear wins over a
// same-cycle step and the count wraps modulo 2^POS_W.
module enc_position_cnt
  import encoder_pkg::*;
#(
  parameter int POS_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    clr,
  input  logic [1:0]              pulse_dir,
  output logic signed [POS_W-1:0] position
);

  localparam logic signed [POS_W-1:0] ONE = POS_W'(1);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      position <= '0;
    end else if (pulse_dir == PD_FWD) begin
      position <= position + ONE;
    end else if (pulse_dir == PD_REV) begin
      position <= position - ONE;
    end
  end

endmodule

// File: rtl/line_trigger_gen.sv
// Line-acquisition trigger generator: one fixed-width trigger per accepted
// direction pulse with hold-off, line-in-frame tagging and a missed-pulse
// counter. Optional TIMESTAMP output when LINE_TRIG_TIMESTAMP_EN is defined.
module line_trigger_gen
  import encoder_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENABLE,
  input  logic                    POS_CLR,
  input  logic [1:0]              DIR_MODE,
  input  logic [CNT_W-1:0]        TRIG_WIDTH,
  input  logic [CNT_W-1:0]        HOLDOFF,
  input  logic [CNT_W-1:0]        LINES_PER_FRAME,
  input  logic [1:0]              PULSE_DIR,
  output logic                    LINE_TRIG,
  output logic                    FRAME_START,
  output logic [CNT_W-1:0]        LINE_IDX,
  output logic signed [POS_W-1:0] POSITION,
  output logic [CNT_W-1:0]        MISSED_CNT
`ifdef LINE_TRIG_TIMESTAMP_EN
  ,
  output logic [31:0]             TIMESTAMP
`endif
);

  logic             en_p0, en_p1;
  logic [1:0]       mode_p0;
  logic [CNT_W-1:0] tw_p0, ho_p0, lpf_p0, ho_w;
  trig_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nxt_idx, line_idx_q, missed_q;
  logic [CNT_W-1:0] lpf_eff, base_idx, use_idx;
  logic             accept, busy_miss, en_rise, start, frame_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: configuration registered once; hold-off frozen outside IDLE
  always_ff @(posedge CLK) begin
    if (RST) begin
      en_p0   <= 1'b0;
      en_p1   <= 1'b0;
      mode_p0 <= '0;
      tw_p0   <= '0;
      ho_p0   <= '0;
      lpf_p0  <= '0;
      ho_w    <= '0;
    end else begin
      en_p0   <= ENABLE;
      en_p1   <= en_p0;
      mode_p0 <= DIR_MODE;
      tw_p0   <= TRIG_WIDTH;
      ho_p0   <= HOLDOFF;
      lpf_p0  <= LINES_PER_FRAME;
      if (state_q == ST_IDLE) ho_w <= ho_p0;
    end
  end

  assign accept    = en_p0 && pulse_accepted(mode_p0, PULSE_DIR);
  assign busy_miss = accept && (state_q != ST_IDLE);
  assign en_rise   = en_p0 && !en_p1;
  assign lpf_eff   = (lpf_p0 == '0) ? CNT_W'(1) : lpf_p0;
  assign base_idx  = en_rise ? '0 : nxt_idx;
  // A frame shortened below the pending index restarts at line 0.
  assign use_idx   = (base_idx >= lpf_eff) ? '0 : base_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_TRIG;
          cnt_d   = (tw_p0 == '0) ? '0 : tw_p0 - 1'b1;
          start   = 1'b1;
        end
      end
      ST_TRIG: begin
        if (cnt_q == '0) begin
          if (ho_w != '0) begin
            state_d = ST_HOLDOFF;
            cnt_d   = ho_w - 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: FSM state, line tagging and missed-pulse accounting
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      line_idx_q <= '0;
      nxt_idx    <= '0;
      frame_q    <= 1'b0;
      missed_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= 1'b0;
      if (start) begin
        line_idx_q <= use_idx;
        nxt_idx    <= (use_idx >= lpf_eff - 1'b1) ? '0 : use_idx + 1'b1;
        frame_q    <= (use_idx == '0);
      end else if (en_rise) begin
        line_idx_q <= '0;
        nxt_idx    <= '0;
      end
      if (en_rise)        missed_q <= busy_miss ? CNT_W'(1) : '0;
      else if (busy_miss) missed_q <= sat_inc(missed_q);
    end
  end

  assign LINE_TRIG   = (state_q == ST_TRIG);
  assign FRAME_START = frame_q;
  assign LINE_IDX    = line_idx_q;
  assign MISSED_CNT  = missed_q;

`ifdef LINE_TRIG_TIMESTAMP_EN
  logic [31:0] ts_q, ts_hold;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ts_q    <= '0;
      ts_hold <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (start) ts_hold <= ts_q;
    end
  end

  assign TIMESTAMP = ts_hold;
`endif

  enc_position_cnt #(.POS_W(POS_W)) u_pos (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (POS_CLR),
    .pulse_dir (PULSE_DIR),
    .position  (POSITION)
  );

endmodule

// File: tb/tb_line_trigger_gen.sv
// Self-checking bench for line_trigger_gen: directed scenarios plus randomized
// traffic against an interval-based reference model.
module tb_line_trigger_gen;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b0, POS_CLR = 1'b0;
  logic [1:0]  DIR_MODE = 2'd0, PULSE_DIR = 2'd0;
  logic [15:0] TRIG_WIDTH = '0, HOLDOFF = '0, LINES_PER_FRAME = '0;
  logic        LINE_TRIG, FRAME_START;
  logic [15:0] LINE_IDX, MISSED_CNT;
  logic signed [31:0] POSITION;
`ifdef LINE_TRIG_TIMESTAMP_EN
  logic [31:0] TIMESTAMP;
`endif

  always #5 CLK = ~CLK;

  line_trigger_gen #(.CNT_W(16), .POS_W(32)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .POS_CLR(POS_CLR), .DIR_MODE(DIR_MODE),
    .TRIG_WIDTH(TRIG_WIDTH), .HOLDOFF(HOLDOFF), .LINES_PER_FRAME(LINES_PER_FRAME),
    .PULSE_DIR(PULSE_DIR), .LINE_TRIG(LINE_TRIG), .FRAME_START(FRAME_START),
    .LINE_IDX(LINE_IDX), .POSITION(POSITION), .MISSED_CNT(MISSED_CNT)
`ifdef LINE_TRIG_TIMESTAMP_EN
    , .TIMESTAMP(TIMESTAMP)
`endif
  );

  int nvec = 0, nerr = 0;

  // Reference model: cycle index of the observed outputs, trigger window,
  // last busy cycle, frame bookkeeping; m_* config copies lag inputs by one cycle.
  int          cyc;
  logic [31:0] m_pos, m_ts;
  int          m_lo, m_hi, m_busy, m_idx, m_next, m_missed;
  int          m_tw, m_ho, m_lpf;
  logic        m_en, m_rise;
  logic [1:0]  m_mode;

  task automatic model_reset();
    cyc = 0; m_pos = '0; m_ts = '0;
    m_lo = -100; m_hi = -100; m_busy = -1;
    m_idx = 0; m_next = 0; m_missed = 0;
    m_tw = 0; m_ho = 0; m_lpf = 0; m_en = 1'b0; m_rise = 1'b0; m_mode = 2'd0;
  endtask

  task automatic do_reset();
    RST = 1'b1; PULSE_DIR = 2'b00; POS_CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic [1:0] pd, input logic clr);
    int tw, lpf;
    bit acc;
    PULSE_DIR = pd; POS_CLR = clr;
    if (m_rise) begin m_idx = 0; m_next = 0; m_missed = 0; end
    acc = m_en && ((pd == 2'b01 && (m_mode == 2'd0 || m_mode == 2'd2)) ||
                   (pd == 2'b10 && (m_mode == 2'd1 || m_mode == 2'd2)));
    if (acc) begin
      if (cyc > m_busy) begin
        tw  = (m_tw == 0) ? 1 : m_tw;
        lpf = (m_lpf == 0) ? 1 : m_lpf;
        m_lo = cyc + 1; m_hi = cyc + tw; m_busy = cyc + tw + m_ho;
        m_idx = (m_next >= lpf) ? 0 : m_next;
        m_next = (m_idx + 1) % lpf;
        m_ts = cyc;
      end else if (m_missed < 65535) begin
        m_missed++;
      end
    end
    if (clr)              m_pos = '0;
    else if (pd == 2'b01) m_pos = m_pos + 1;
    else if (pd == 2'b10) m_pos = m_pos - 1;
    m_rise = ENABLE && !m_en;
    m_en = ENABLE; m_mode = DIR_MODE;
    m_tw = int'(TRIG_WIDTH); m_ho = int'(HOLDOFF); m_lpf = int'(LINES_PER_FRAME);
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(2'b00, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (LINE_TRIG !== 1'b0) begin nerr++; $display("FAIL reset_line_trig: got %b want 0", LINE_TRIG); end
    nvec++; if (FRAME_START !== 1'b0) begin nerr++; $display("FAIL reset_frame_start: got %b want 0", FRAME_START); end
    nvec++; if (LINE_IDX !== 16'd0) begin nerr++; $display("FAIL reset_line_idx: got %0d want 0", LINE_IDX); end
    nvec++; if (POSITION !== 32'sd0) begin nerr++; $display("FAIL reset_position: got %0d want 0", POSITION); end
    nvec++; if (MISSED_CNT !== 16'd0) begin nerr++; $display("FAIL reset_missed: got %0d want 0", MISSED_CNT); end
  endtask

  task automatic test_trigger_spacing();
    ENABLE = 1'b1; DIR_MODE = 2'd2; TRIG_WIDTH = 16'd3; HOLDOFF = 16'd2; LINES_PER_FRAME = 16'd4;
    idle(3);
    step(2'b01, 1'b0);
    nvec++; if (POSITION !== 32'sd1) begin nerr++; $display("FAIL t1_position: got %0d want 1", POSITION); end
    for (int k = 1; k <= 6; k++) begin
      nvec++;
      if (LINE_TRIG !== (k <= 3)) begin nerr++; $display("FAIL t1_trig_n+%0d: got %b want %b", k, LINE_TRIG, (k <= 3)); end
      step(2'b00, 1'b0);
    end
    step(2'b01, 1'b0);
    nvec++; if (LINE_TRIG !== 1'b1) begin nerr++; $display("FAIL t1_retrigger: got %b want 1", LINE_TRIG); end
    nvec++; if (MISSED_CNT !== 16'd0) begin nerr++; $display("FAIL t1_missed: got %0d want 0", MISSED_CNT); end
    nvec++; if (LINE_IDX !== 16'd1) begin nerr++; $display("FAIL t1_line_idx: got %0d want 1", LINE_IDX); end
  endtask

  task automatic test_missed();
    TRIG_WIDTH = 16'd4; HOLDOFF = 16'd4;
    idle(12);
    step(2'b01, 1'b0);
    nvec++; if (LINE_TRIG !== 1'b1) begin nerr++; $display("FAIL t2_trig: got %b want 1", LINE_TRIG); end
    idle(2);
    step(2'b01, 1'b0);
    nvec++; if (MISSED_CNT !== 16'd1) begin nerr++; $display("FAIL t2_missed_busy: got %0d want 1", MISSED_CNT); end
    idle(4);
    step(2'b01, 1'b0);
    nvec++; if (MISSED_CNT !== 16'd2) begin nerr++; $display("FAIL t2_missed_last_holdoff: got %0d want 2", MISSED_CNT); end
    nvec++; if (LINE_TRIG !== 1'b0) begin nerr++; $display("FAIL t2_no_trig: got %b want 0", LINE_TRIG); end
    step(2'b00, 1'b0);
    nvec++; if (LINE_TRIG !== 1'b0) begin nerr++; $display("FAIL t2_no_trig_late: got %b want 0", LINE_TRIG); end
  endtask

  task automatic test_frame();
    ENABLE = 1'b0; LINES_PER_FRAME = 16'd3; TRIG_WIDTH = 16'd1; HOLDOFF = 16'd0;
    idle(3);
    ENABLE = 1'b1;
    idle(3);
    nvec++; if (LINE_IDX !== 16'd0) begin nerr++; $display("FAIL t6_enable_clears_idx: got %0d want 0", LINE_IDX); end
    nvec++; if (MISSED_CNT !== 16'd0) begin nerr++; $display("FAIL t6_enable_clears_missed: got %0d want 0", MISSED_CNT); end
    for (int i = 0; i < 7; i++) begin
      step(2'b01, 1'b0);
      nvec++; if (LINE_TRIG !== 1'b1) begin nerr++; $display("FAIL t3_trig_%0d: got %b want 1", i, LINE_TRIG); end
      nvec++; if (LINE_IDX !== 16'(i % 3)) begin nerr++; $display("FAIL t3_idx_%0d: got %0d want %0d", i, LINE_IDX, i % 3); end
      nvec++; if (FRAME_START !== (i % 3 == 0)) begin nerr++; $display("FAIL t3_fs_%0d: got %b want %b", i, FRAME_START, (i % 3 == 0)); end
      step(2'b00, 1'b0);
      nvec++; if (FRAME_START !== 1'b0) begin nerr++; $display("FAIL t3_fs_drop_%0d: got %b want 0", i, FRAME_START); end
      step(2'b00, 1'b0);
    end
  endtask

  task automatic test_position();
    DIR_MODE = 2'd0;
    idle(2);
    step(2'b00, 1'b1);
    nvec++; if (POSITION !== 32'sd0) begin nerr++; $display("FAIL t4_clear: got %0d want 0", POSITION); end
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 1'b0);
      nvec++; if (LINE_TRIG !== 1'b0) begin nerr++; $display("FAIL t4_rev_no_trig_%0d: got %b want 0", i, LINE_TRIG); end
      step(2'b00, 1'b0);
    end
    nvec++; if (POSITION !== 32'hFFFF_FFFB) begin nerr++; $display("FAIL t4_pos_minus5: got %h want fffffffb", POSITION); end
    step(2'b01, 1'b1);
    nvec++; if (POSITION !== 32'sd0) begin nerr++; $display("FAIL t4_clr_priority: got %0d want 0", POSITION); end
    nvec++; if (LINE_TRIG !== 1'b1) begin nerr++; $display("FAIL t4_fwd_trig: got %b want 1", LINE_TRIG); end
    idle(3);
  endtask

  task automatic test_degenerate();
    DIR_MODE = 2'd2; TRIG_WIDTH = 16'd0; HOLDOFF = 16'd0; LINES_PER_FRAME = 16'd0;
    idle(3);
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b0);
      nvec++; if (LINE_TRIG !== 1'b1) begin nerr++; $display("FAIL t5_trig_%0d: got %b want 1", i, LINE_TRIG); end
      nvec++; if (LINE_IDX !== 16'd0) begin nerr++; $display("FAIL t5_idx_%0d: got %0d want 0", i, LINE_IDX); end
      nvec++; if (FRAME_START !== 1'b1) begin nerr++; $display("FAIL t5_fs_%0d: got %b want 1", i, FRAME_START); end
      step(2'b00, 1'b0);
      nvec++; if (LINE_TRIG !== 1'b0) begin nerr++; $display("FAIL t5_width1_%0d: got %b want 0", i, LINE_TRIG); end
    end
    step(2'b11, 1'b0);
    nvec++; if (LINE_TRIG !== 1'b0) begin nerr++; $display("FAIL t5_both_no_trig: got %b want 0", LINE_TRIG); end
    nvec++; if (POSITION !== 32'sd3) begin nerr++; $display("FAIL t5_both_pos: got %0d want 3", POSITION); end
  endtask

  task automatic test_reset_mid();
    int n;
    TRIG_WIDTH = 16'd5; HOLDOFF = 16'd0;
    idle(3);
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    nvec++; if (LINE_TRIG !== 1'b1) begin nerr++; $display("FAIL t6_trig_2nd: got %b want 1", LINE_TRIG); end
    nvec++; if (MISSED_CNT !== 16'd1) begin nerr++; $display("FAIL t6_missed: got %0d want 1", MISSED_CNT); end
    RST = 1'b1; PULSE_DIR = 2'b00;
    @(posedge CLK); #1;
    nvec++; if (LINE_TRIG !== 1'b0) begin nerr++; $display("FAIL t6_rst_trig: got %b want 0", LINE_TRIG); end
    nvec++; if (POSITION !== 32'sd0) begin nerr++; $display("FAIL t6_rst_pos: got %0d want 0", POSITION); end
    nvec++; if (MISSED_CNT !== 16'd0) begin nerr++; $display("FAIL t6_rst_missed: got %0d want 0", MISSED_CNT); end
    nvec++; if (FRAME_START !== 1'b0 || LINE_IDX !== 16'd0) begin nerr++; $display("FAIL t6_rst_frame: got %b/%0d want 0/0", FRAME_START, LINE_IDX); end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(2'b00, 1'b0);
      nvec++; if (LINE_TRIG !== 1'b0) begin nerr++; $display("FAIL t6_no_resume_%0d: got %b want 0", i, LINE_TRIG); end
    end
    n = cyc;
    step(2'b10, 1'b0);
    nvec++; if (LINE_TRIG !== 1'b1 || LINE_IDX !== 16'd0) begin nerr++; $display("FAIL t6_after_rst: got %b/%0d want 1/0", LINE_TRIG, LINE_IDX); end
`ifdef LINE_TRIG_TIMESTAMP_EN
    nvec++; if (TIMESTAMP !== 32'(n)) begin nerr++; $display("FAIL t6_timestamp: got %0d want %0d", TIMESTAMP, n); end
`endif
    idle(6);
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      ENABLE = 1'b0;
      DIR_MODE = 2'($urandom_range(0, 3));
      TRIG_WIDTH = 16'($urandom_range(0, 6));
      HOLDOFF = 16'($urandom_range(0, 5));
      LINES_PER_FRAME = 16'($urandom_range(0, 4));
      idle(3);
      ENABLE = 1'b1;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 39) == 0) begin
          TRIG_WIDTH = 16'($urandom_range(0, 6));
          HOLDOFF = 16'($urandom_range(0, 5));
          DIR_MODE = 2'($urandom_range(0, 2));
        end
        if ($urandom_range(0, 49) == 0) ENABLE = ~ENABLE;
        r = $urandom_range(0, 9);
        step((r < 3) ? 2'b01 : (r < 5) ? 2'b10 : (r == 5) ? 2'b11 : 2'b00, ($urandom_range(0, 29) == 0));
        nvec++; if (LINE_TRIG !== (cyc >= m_lo && cyc <= m_hi)) begin nerr++; $display("FAIL rnd_trig c%0d: got %b want %b", cyc, LINE_TRIG, (cyc >= m_lo && cyc <= m_hi)); end
        nvec++; if (FRAME_START !== (cyc == m_lo && m_idx == 0)) begin nerr++; $display("FAIL rnd_fs c%0d: got %b want %b", cyc, FRAME_START, (cyc == m_lo && m_idx == 0)); end
        nvec++; if (LINE_IDX !== 16'(m_idx)) begin nerr++; $display("FAIL rnd_idx c%0d: got %0d want %0d", cyc, LINE_IDX, m_idx); end
        nvec++; if (MISSED_CNT !== 16'(m_missed)) begin nerr++; $display("FAIL rnd_missed c%0d: got %0d want %0d", cyc, MISSED_CNT, m_missed); end
        nvec++; if (POSITION !== m_pos) begin nerr++; $display("FAIL rnd_pos c%0d: got %h want %h", cyc, POSITION, m_pos); end
`ifdef LINE_TRIG_TIMESTAMP_EN
        nvec++; if (TIMESTAMP !== m_ts) begin nerr++; $display("FAIL rnd_ts c%0d: got %0d want %0d", cyc, TIMESTAMP, m_ts); end
`endif
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_trigger_spacing();
    test_missed();
    test_frame();
    test_position();
    test_degenerate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
